// File: rtl/misc_pkg.sv
// Shared mode constants for muxes and arbiters.
// Selects how an arbitrated mux picks among requesters.
package misc_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/arb_mux_rr_picker.sv
// Combinational round-robin picker: first request at or after ptr.
// Doubling the request vector turns the wrap-around into a linear search.
module rr_picker #(
    parameter int N_IN = 4,
    localparam int IW  = $clog2(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [N_IN-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [2*N_IN-1:0] dbl;
    logic              found;

    // Lowest set bit of {req,req} at position >= ptr, folded back mod N_IN
    always_comb begin
        dbl   = {req, req};
        found = 1'b0;
        idx   = '0;
        grant = '0;
        for (int j = 0; j < 2*N_IN; j++) begin
            if (!found && dbl[j] && (j >= int'(ptr))) begin
                found = 1'b1;
                idx   = IW'(j % N_IN);
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N:1 arbitrated mux with valid/ready inputs and a registered output.
// Round-robin or fixed-priority grant; one transfer per cycle when open.
module arb_mux
    import misc_pkg::*;
#(
    parameter int        WIDTH = 32,
    parameter int        N_IN  = 4,
    parameter arb_mode_e MODE  = ARB_RR,
    localparam int       IW    = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IW-1:0]         out_sel
);

    logic              load;
    logic              accept;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     ptr_eff;
    logic [N_IN-1:0]   grant;
    logic [IW-1:0]     win;
    logic [IW-1:0]     ptr_next;
    logic [WIDTH-1:0]  sel_data;

    // Output register can take a new beat when empty or draining now
    assign load = ~out_valid | out_ready;

    // Fixed priority is round-robin searching from channel 0
    assign ptr_eff = (MODE == ARB_FIXED) ? '0 : ptr;

    rr_picker #(
        .N_IN (N_IN)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr_eff),
        .grant (grant),
        .idx   (win)
    );

    assign in_ready = rst ? '0 : (grant & {N_IN{load}});
    assign accept   = |(in_valid & in_ready);

    // Explicit wrap so non-power-of-two channel counts return to 0
    assign ptr_next = (win == IW'(N_IN-1)) ? '0 : win + IW'(1);

    // AND-OR payload select over the one-hot grant
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            sel_data = sel_data
                     | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= win;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N:1 arbitrated multiplexer with a registered output stage. It is the successor to the fixed 4:1 gate-level select mux. The select comes from an internal arbiter (round-robin or fixed-priority) instead of an external select bus, and each input uses a valid/ready handshake. Dispatch and writeback paths use it wherever several producers share one downstream port, for example functional units competing for a CDB slot.

## Interface
- `WIDTH`, default 32: payload width per channel.
- `N_IN`, default 4: number of input channels, ≥2.
- `MODE`, default `ARB_RR`: `ARB_RR` is round-robin; `ARB_FIXED` gives the lowest index highest priority.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, `N_IN` bits: per-channel request.
- `in_data` input, `N_IN*WIDTH` bits: channel i occupies `[i*WIDTH +: WIDTH]`.
- `in_ready` output, `N_IN` bits: one-hot or zero; channel i is accepted on cycles where `in_valid[i] & in_ready[i]`.
- `out_valid` output, 1 bit: the output register holds a transfer.
- `out_ready` input, 1 bit: downstream accepts.
- `out_data` output, `WIDTH` bits: registered payload.
- `out_sel` output, `$clog2(N_IN)` bits: index of the channel that produced `out_data`.

## Operation
- **Output stage can load:** `load = ~out_valid | out_ready`.
- **Grant:** combinational one-hot over `in_valid`.
  - `ARB_RR`: the first valid channel at or after `ptr`, searching upward with wrap-around.
  - `ARB_FIXED`: the lowest valid index; `ptr` is ignored.
- **Ready:** `in_ready = grant & {N_IN{load}}`. It is forced to all-zero while `rst` is high.
- **On accept** (any `in_valid & in_ready`): `out_data`, `out_sel` and `out_valid=1` are registered from the granted channel.
- **Emptying:** if `out_valid & out_ready` and there is no new accept, `out_valid` goes to 0.
- **Pointer:** `ptr` moves to `(winner+1) mod N_IN` only on accept. With `N_IN` not a power of two, `N_IN-1` wraps to 0.
- **Stall:** while `out_valid & ~out_ready`, the block makes no grant, `ptr` holds, and `out_data`/`out_sel` stay stable.
- **Dropped requests:** a channel that drops `in_valid` before being accepted loses nothing, because nothing is latched until accept.
- **Reset values:** `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
- **Reset mid-transfer:** the held output is discarded, and the next accept after reset follows `ptr=0` order.

## Timing
- Latency is 1 cycle, from the accept edge to `out_valid` high.
- Throughput is 1 transfer/cycle while `out_ready=1`. A simultaneous drain and refill in the same cycle must produce no bubble.
- The combinational path runs `in_valid`/`out_ready` to `in_ready`.
- There is no combinational path from `in_data` to `out_data`.
- `out_ready` may toggle every cycle. It is a registered-output design; there is no skid buffer.

## Structure
- The `ARB_RR`/`ARB_FIXED` mode constants go in the shared `misc_pkg`, alongside future mux/arbiter modes.
- Sub-module `rr_picker #(N_IN)`: combinational. Inputs are `req` and `ptr`; outputs are one-hot `grant` and binary `idx`. Implement it as a double-width masked priority search.
- The top level holds the output register, `ptr` register, handshake logic and payload select (AND-OR over the one-hot grant).

## Test plan
Configuration for all scenarios: `N_IN=4`, `WIDTH=8`, `ARB_RR` unless stated.
1. **Reset:** hold `rst` for 2 cycles with all `in_valid=1` → `in_ready=0000`, `out_valid=0`, `out_data=0`. The first accept after release is ch0.
2. **Single request:** ch2 valid with `0xA5`, `out_ready=1` → `in_ready=0100` in the same cycle. The next cycle shows `out_valid=1`, `out_data=0xA5`, `out_sel=2`. Then `ptr=3`.
3. **Full contention:** all channels valid with data `0x10+i`, `out_ready=1` → `out_sel` sequence 0,1,2,3,0,1 on consecutive cycles, with no idle cycles.
4. **Backpressure:** ch1 held valid, `out_ready=0` for 3 cycles after ch0 is latched → `out_data` stable at ch0, `in_ready=0000`, `ptr` unchanged. When `out_ready` rises, ch1 is accepted in that same cycle.
5. **Fixed mode** (`ARB_FIXED`): ch1 and ch3 continuously valid → `out_sel=1` every cycle, and ch3 is never granted.
6. **Reset mid-stall:** `out_valid=1` with `out_ready=0`, then assert `rst` for 1 cycle → `out_valid=0` on the next cycle. After release, with ch3 and ch0 valid, ch0 wins.
